// File: rtl/dht11_responder.sv
`timescale 1ns/1ps
// DHT11 device-side responder: detects the host start pulse, answers with the
// acknowledge, then shifts out {data_in, checksum} MSB first on the open-drain bus.
module dht11_responder #(
  parameter int CLK_FREQ_MHZ  = 50,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 13,
  parameter int ACK_LOW_US    = 80,
  parameter int ACK_HIGH_US   = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 26,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  inout  wire         dht11,
  input  logic [31:0] data_in,
  input  logic        inject_err,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HOST_LOW, ST_RESP_DELAY, ST_ACK_LOW,
    ST_ACK_HIGH, ST_BIT_LOW, ST_BIT_HIGH, ST_EOF
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   us_q, us_d;
  logic [39:0]   shreg_q, shreg_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;

  logic          tick, rise, drive_low, phase_end;
  logic [15:0]   us_next, phase_len;
  logic [7:0]    sum;

  assign tick    = (presc_q == PW'(CLK_FREQ_MHZ - 1));
  assign us_next = !tick ? us_q : ((us_q == 16'hFFFF) ? us_q : us_q + 16'd1);
  assign rise    = sync2_q & ~prev_q;
  assign sum     = data_in[31:24] + data_in[23:16] + data_in[15:8] + data_in[7:0];

  // Phase length of the current timed state, in microseconds.
  always_comb begin
    phase_len = 16'd0;
    case (state_q)
      ST_RESP_DELAY: phase_len = 16'(RESP_DELAY_US);
      ST_ACK_LOW:    phase_len = 16'(ACK_LOW_US);
      ST_ACK_HIGH:   phase_len = 16'(ACK_HIGH_US);
      ST_BIT_LOW:    phase_len = 16'(BIT_LOW_US);
      ST_BIT_HIGH:   phase_len = shreg_q[39] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
      ST_EOF:        phase_len = 16'(BIT_LOW_US);
      default:       phase_len = 16'd0;
    endcase
  end

  assign phase_end = tick && (us_q == phase_len - 16'd1);

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    us_d      = us_next;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    sync1_d   = dht11;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;

    case (state_q)
      ST_IDLE: if (!sync2_q) state_d = ST_HOST_LOW;
      ST_HOST_LOW: begin
        // us_next includes a tick landing on the release cycle, so a low of
        // exactly START_MIN_US still qualifies.
        if (rise) begin
          if (us_next >= 16'(START_MIN_US)) begin
            state_d   = ST_RESP_DELAY;
            shreg_d   = {data_in, inject_err ? ~sum : sum};
            bit_cnt_d = 6'd0;
            busy_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP_DELAY: if (phase_end) state_d = ST_ACK_LOW;
      ST_ACK_LOW:    if (phase_end) state_d = ST_ACK_HIGH;
      ST_ACK_HIGH:   if (phase_end) state_d = ST_BIT_LOW;
      ST_BIT_LOW: begin
        if (bit_cnt_q == 6'd40)  state_d = ST_EOF;
        else if (phase_end)      state_d = ST_BIT_HIGH;
      end
      ST_BIT_HIGH: begin
        // After the last bit the trailing low is the EOF low itself, so jump
        // straight there; EOF then lasts exactly BIT_LOW_US.
        if (phase_end) begin
          shreg_d   = {shreg_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? ST_EOF : ST_BIT_LOW;
        end
      end
      ST_EOF: begin
        if (phase_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      presc_d = '0;
      us_d    = 16'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      us_q      <= 16'd0;
      shreg_q   <= 40'd0;
      bit_cnt_q <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= 8'd0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      us_q      <= us_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
    end
  end

  // Drive decodes straight from the state register so reset frees the bus at once.
  assign drive_low  = (state_q == ST_ACK_LOW) || (state_q == ST_BIT_LOW) || (state_q == ST_EOF);
  assign dht11      = drive_low ? 1'b0 : 1'bz;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_dht11_responder.sv
`timescale 1ns/1ps
// Directed bench for dht11_responder: plays the host, decodes frames off the bus
// by pulse widths and checks words, phase timings and status outputs.
module tb_dht11_responder;
  localparam int F = 2, SMIN = 100;
  localparam int RD = 13, AL = 80, AH = 80, BL = 50, B0 = 26, B1 = 70;
  localparam int LIM = 4000;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_low = 1'b0;
  logic        inject_err = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        busy, frame_done;
  logic [7:0]  frame_cnt;
  wire         dht11;
  int          total = 0, bad = 0;

  assign dht11 = host_low ? 1'b0 : 1'bz;
  pullup (dht11);
  always #5 sys_clk = ~sys_clk;

  dht11_responder #(.CLK_FREQ_MHZ(F), .START_MIN_US(SMIN)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .dht11(dht11), .data_in(data_in),
    .inject_err(inject_err), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  function automatic bit bus_hi();
    return dht11 !== 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int frame_cyc(input logic [39:0] w);
    int s;
    s = RD + AL + AH + 40 * BL + BL;
    for (int i = 0; i < 40; i++) s += w[i] ? B1 : B0;
    return s * F;
  endfunction

  task automatic meas(input bit lvl, output int n);
    n = 0;
    while (bus_hi() == lvl && n < LIM) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic host_start(input int cyc);
    @(negedge sys_clk);
    host_low = 1'b1;
    repeat (cyc) @(negedge sys_clk);
    host_low = 1'b0;
  endtask

  task automatic quiet(input int cyc, output int hits);
    hits = 0;
    repeat (cyc) begin
      @(negedge sys_clk);
      if (!bus_hi() || busy) hits++;
    end
  endtask

  // Receive one frame; abort_bit >= 0 asserts reset at that bit's low phase,
  // disturb pulls the bus during ACK_HIGH and changes data_in during bit 5.
  task automatic rx(input int abort_bit, input bit disturb, output logic [39:0] w, output int tot);
    int n, lo, hi, tbad;
    bit to;
    w = '0; tot = 0; tbad = 0; to = 1'b0;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (bus_hi() && n < LIM);
    // n-1 = cycles from the first sampling edge of the released pin
    chk("resp_lat", n - 1, RD * F + 2);
    chk("busy_ack", busy, 1);
    tot = n - 1 - 2;
    meas(1'b0, lo);
    chk("ack_low", lo, AL * F);
    tot += lo;
    if (disturb) begin
      host_low = 1'b1;
      repeat (20) @(negedge sys_clk);
      host_low = 1'b0;
      #1;
      meas(1'b1, hi);
      hi += 20;
    end else begin
      meas(1'b1, hi);
    end
    chk("ack_high", hi, AH * F);
    tot += hi;
    for (int i = 0; i < 40 && !to; i++) begin
      if (i == abort_bit) begin
        rst_n = 1'b0;
        #1;
        chk("abort_rel", bus_hi(), 1);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", frame_cnt, 0);
        return;
      end
      if (i == 5 && disturb) data_in = 32'h1111_1111;
      meas(1'b0, lo);
      meas(1'b1, hi);
      if (lo != BL * F || (hi != B0 * F && hi != B1 * F)) tbad++;
      if (lo >= LIM || hi >= LIM) to = 1'b1;
      w = {w[38:0], hi > (B0 + B1) * F / 2};
      tot += lo + hi;
    end
    chk("bit_timing", tbad, 0);
    chk("timeout", to, 0);
    meas(1'b0, lo);
    chk("eof_low", lo, BL * F);
    tot += lo;
    chk("done_pulse", frame_done, 1);
    chk("busy_end", busy, 0);
    @(negedge sys_clk);
    chk("done_once", frame_done, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] w;
    int tot, hits, err;

    err = 0;
    for (int i = 0; i < 24; i++) begin
      host_low = (i % 6) < 3;
      @(negedge sys_clk);
      if ((!host_low && !bus_hi()) || busy !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 8'd0) err++;
    end
    host_low = 1'b0;
    chk("rst_hold", err, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("rst_cnt", frame_cnt, 0);

    data_in = 32'h3A00_1900;
    host_start((SMIN + 20) * F);
    rx(-1, 1'b0, w, tot);
    chk("nom_word", w, 40'h3A_00_19_00_53);
    chk("nom_len", tot, frame_cyc(40'h3A_00_19_00_53));
    chk("nom_cnt", frame_cnt, 1);

    host_start(10 * F);
    quiet(600, hits);
    chk("short_glitch", hits, 0);
    host_start((SMIN - 1) * F);
    quiet(600, hits);
    chk("short_min1", hits, 0);

    data_in = 32'hFFFF_FFFF;
    host_start(SMIN * F);
    rx(-1, 1'b0, w, tot);
    chk("ff_word", w, 40'hFF_FF_FF_FF_FC);
    chk("ff_cnt", frame_cnt, 2);

    inject_err = 1'b1;
    host_start((SMIN + 20) * F);
    rx(-1, 1'b0, w, tot);
    inject_err = 1'b0;
    chk("inj_word", w, 40'hFF_FF_FF_FF_03);
    chk("inj_cnt", frame_cnt, 3);

    data_in = 32'h1234_5678;
    host_start((SMIN + 20) * F);
    rx(-1, 1'b1, w, tot);
    chk("latch_word", w, 40'h12_34_56_78_14);
    chk("latch_cnt", frame_cnt, 4);

    data_in = 32'h0000_0000;
    host_start((SMIN + 20) * F);
    rx(20, 1'b0, w, tot);
    repeat (4) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    host_start((SMIN + 20) * F);
    rx(-1, 1'b0, w, tot);
    chk("zero_word", w, 40'h00_00_00_00_00);
    chk("zero_len", tot, 3263 * F);
    chk("zero_cnt", frame_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
